// File: rtl/gray_pkg.sv
// gray_pkg: shared types for the grayscale-core arbiter (FSM states, in-flight tag, ID width helper).
package gray_pkg;
    typedef enum logic {IDLE, XFER} state_e;

    localparam int MAX_ID_W = 2;

    typedef struct packed {
        logic [MAX_ID_W-1:0] id;
        logic                last;
    } tag_t;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/gray_tag_fifo.sv
// gray_tag_fifo: synchronous FIFO of in-flight tags with registered storage and full/empty flags.
module gray_tag_fifo
    import gray_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  tag_t din,
    output tag_t dout,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);

    tag_t       mem_q [DEPTH];
    logic [AW:0] wr_q, rd_q;
    logic        do_push, do_pop;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign empty   = wr_q == rd_q;
    assign full    = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_q + (AW+1)'(do_push);
            rd_q <= rd_q + (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/gray_arbiter.sv
// gray_arbiter: packet-granular round-robin sharing of one grayscale core among N_REQ RGB streams;
// a tag FIFO routes the in-order results back to the requester that issued them.
module gray_arbiter
    import gray_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int N_REQ      = 2,
    parameter int TAG_DEPTH  = 8,
    localparam int ID_W      = id_w(N_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ*3*DATA_WIDTH-1:0] s_tdata,
    input  logic [N_REQ-1:0]              s_tvalid,
    input  logic [N_REQ-1:0]              s_tlast,
    output logic [N_REQ-1:0]              s_tready,
    output logic [3*DATA_WIDTH-1:0]       c_tdata,
    output logic                          c_tvalid,
    input  logic                          c_tready,
    input  logic [DATA_WIDTH-1:0]         c_rdata,
    input  logic                          c_rvalid,
    output logic                          c_rready,
    output logic [N_REQ*DATA_WIDTH-1:0]   m_tdata,
    output logic [N_REQ-1:0]              m_tvalid,
    output logic [N_REQ-1:0]              m_tlast,
    input  logic [N_REQ-1:0]              m_tready,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy,
    output logic                          err_orphan
);
    localparam int PW = 3 * DATA_WIDTH;

    state_e          state_q, state_d;
    logic [ID_W-1:0] grant_q, grant_d, last_q, last_d, pick, head_id;
    logic            orphan_q, orphan_d, rst_q, quiet, any_req, issue_ok;
    logic            push, pop, full, empty;
    tag_t            tag_in, head;

    // Outputs stay silent for the reset cycle and the one after it.
    assign quiet = rst | rst_q;

    // Later candidates overwrite earlier ones, so the nearest valid after last_q wins.
    always_comb begin
        pick    = last_q;
        any_req = 1'b0;
        for (int k = N_REQ; k >= 1; k--) begin
            if (s_tvalid[(int'(last_q) + k) % N_REQ]) begin
                pick    = ID_W'((int'(last_q) + k) % N_REQ);
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        if (state_q == IDLE) begin
            if (any_req) begin
                state_d = XFER;
                grant_d = pick;
                last_d  = pick;
            end
        end else if (push && s_tlast[grant_q]) begin
            state_d = IDLE;
        end
        orphan_d = orphan_q | (!quiet && c_rvalid && empty);
    end

    assign issue_ok = !quiet && state_q == XFER && !full;
    assign c_tdata  = s_tdata[int'(grant_q)*PW +: PW];
    assign c_tvalid = issue_ok && s_tvalid[grant_q];
    assign s_tready = N_REQ'(issue_ok && c_tready) << grant_q;
    assign push     = c_tvalid && c_tready;
    assign tag_in   = '{id: MAX_ID_W'(grant_q), last: s_tlast[grant_q]};

    assign head_id  = ID_W'(head.id);
    assign c_rready = !quiet && (empty ? c_rvalid : m_tready[head_id]);
    assign pop      = c_rvalid && c_rready && !empty;
    assign m_tvalid = (!quiet && !empty && c_rvalid) ? N_REQ'(1) << head_id : '0;
    assign m_tlast  = (!empty && head.last) ? N_REQ'(1) << head_id : '0;
    assign m_tdata  = {N_REQ{c_rdata}};

    assign grant_id   = grant_q;
    assign busy       = !quiet && (state_q == XFER || !empty);
    assign err_orphan = orphan_q;

    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            last_q   <= ID_W'(N_REQ - 1);
            orphan_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            orphan_q <= orphan_d;
        end
    end

    gray_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (tag_in),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );
endmodule

// File: tb/tb_gray_arbiter.sv
// tb_gray_arbiter: drives RGB packets and a model grayscale core (gray = (R+G+B)/3, in order, fixed or
// random latency); per-port result queues are checked against what each requester sent.
module tb_gray_arbiter;
    localparam int DW = 8;
    localparam int N  = 2;
    localparam int PW = 3 * DW;

    logic            clk, rst;
    logic [N*PW-1:0] s_tdata;
    logic [N-1:0]    s_tvalid, s_tlast, s_tready;
    logic [PW-1:0]   c_tdata;
    logic            c_tvalid, c_tready;
    logic [DW-1:0]   c_rdata;
    logic            c_rvalid, c_rready;
    logic [N*DW-1:0] m_tdata;
    logic [N-1:0]    m_tvalid, m_tlast, m_tready;
    logic [0:0]      grant_id;
    logic            busy, err_orphan;

    gray_arbiter #(.DATA_WIDTH(DW), .N_REQ(N), .TAG_DEPTH(8)) dut (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .c_tdata(c_tdata), .c_tvalid(c_tvalid), .c_tready(c_tready),
        .c_rdata(c_rdata), .c_rvalid(c_rvalid), .c_rready(c_rready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .grant_id(grant_id), .busy(busy), .err_orphan(err_orphan)
    );

    typedef struct { logic [PW-1:0] rgb; logic last; } beat_t;
    typedef struct { logic [DW-1:0] d; logic last; } res_t;
    typedef struct { logic [DW-1:0] d; int due; } core_t;
    typedef struct { int src; int beats; logic [PW-1:0] rgb; logic [DW-1:0] exp; } vec_t;

    beat_t srcq [N][$];
    res_t  expq [N][$];
    res_t  rxq  [N][$];
    core_t coreq[$];
    int    issue_log[$];
    int    n_chk = 0, n_fail = 0, cyc = 0;
    bit    rnd = 0, inject = 0, inj_now = 0;
    bit    hold [N];

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] gray(input logic [PW-1:0] rgb);
        return DW'((int'(rgb[23:16]) + int'(rgb[15:8]) + int'(rgb[7:0])) / 3);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Model of the requesters and the core: observe handshakes mid-cycle, update just after the edge.
    initial begin : bfm
        logic [N-1:0]  s_hs;
        logic          c_hs, r_hs;
        logic [PW-1:0] c_d;
        int            due;
        forever begin
            @(negedge clk);
            c_hs = c_tvalid & c_tready;
            r_hs = c_rvalid & c_rready;
            c_d  = c_tdata;
            s_hs = s_tvalid & s_tready;
            for (int i = 0; i < N; i++) begin
                if (m_tvalid[i] && m_tready[i]) rxq[i].push_back('{m_tdata[i*DW +: DW], m_tlast[i]});
                if (s_hs[i] && srcq[i].size() > 0) chk("issue_data", 32'(c_d), 32'(srcq[i][0].rgb));
            end
            if (c_hs || s_hs != '0) chk("issue_hs", 32'(c_hs), 32'(|s_hs));
            if ($countones(m_tvalid) > 1) chk("m_onehot", 32'(m_tvalid), 32'(0));
            @(posedge clk);
            #1;
            cyc++;
            for (int i = 0; i < N; i++) begin
                if (s_hs[i] && srcq[i].size() > 0) begin
                    void'(srcq[i].pop_front());
                    issue_log.push_back(i);
                end
            end
            if (c_hs) begin
                due = cyc + (rnd ? int'($urandom_range(1, 4)) : 2) - 1;
                if (coreq.size() > 0 && coreq[$].due > due) due = coreq[$].due;
                coreq.push_back('{gray(c_d), due});
            end
            if (r_hs && !inj_now && coreq.size() > 0) void'(coreq.pop_front());
            inj_now = inject && coreq.size() == 0;
            if (inj_now) inject = 0;
            for (int i = 0; i < N; i++) begin
                s_tvalid[i] = srcq[i].size() > 0;
                s_tdata[i*PW +: PW] = s_tvalid[i] ? srcq[i][0].rgb : '0;
                s_tlast[i] = s_tvalid[i] ? srcq[i][0].last : 1'b0;
                m_tready[i] = hold[i] ? 1'b0 : (rnd ? ($urandom % 3 != 0) : 1'b1);
            end
            c_rvalid = inj_now || (coreq.size() > 0 && coreq[0].due <= cyc);
            c_rdata  = inj_now ? 8'hEE : (coreq.size() > 0 ? coreq[0].d : '0);
            c_tready = rnd ? ($urandom % 4 != 0) : 1'b1;
        end
    end

    task automatic clr();
        for (int i = 0; i < N; i++) begin
            rxq[i].delete();
            expq[i].delete();
        end
        issue_log.delete();
    endtask

    task automatic send_pkt(input int src, input int beats, input logic [PW-1:0] rgb, input bit rnd_rgb);
        logic [PW-1:0] v;
        for (int b = 0; b < beats; b++) begin
            v = rnd_rgb ? PW'($urandom) : rgb;
            srcq[src].push_back('{v, b == beats - 1});
            expq[src].push_back('{gray(v), b == beats - 1});
        end
    endtask

    // Call from just after a rising edge; the core model is reset together with the DUT.
    task automatic do_reset();
        rst = 1;
        coreq.delete();
        inject = 0;
        for (int i = 0; i < N; i++) begin
            srcq[i].delete();
            rxq[i].delete();
            expq[i].delete();
            hold[i] = 0;
        end
        @(negedge clk);
        chk("rst_outputs_idle", 32'({s_tready, c_tvalid, m_tvalid, c_rready, busy}), 32'(0));
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 0;
        @(negedge clk);
        chk("post_rst_outputs_idle", 32'({s_tready, c_tvalid, m_tvalid, c_rready, busy}), 32'(0));
        chk("post_rst_grant_id", 32'(grant_id), 32'(0));
        chk("post_rst_err_orphan", 32'(err_orphan), 32'(0));
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input int max_cyc);
        bit done = 0;
        for (int c = 0; c < max_cyc && !done; c++) begin
            @(posedge clk);
            #2;
            done = coreq.size() == 0 && !inject && !busy;
            for (int i = 0; i < N; i++) if (srcq[i].size() != 0) done = 0;
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_idle: still busy after %0d cycles, required idle", max_cyc);
        end
    endtask

    task automatic compare_all(input string tag);
        for (int i = 0; i < N; i++) begin
            chk({tag, "_count"}, 32'(rxq[i].size()), 32'(expq[i].size()));
            for (int j = 0; j < rxq[i].size() && j < expq[i].size(); j++) begin
                chk({tag, "_data"}, 32'(rxq[i][j].d), 32'(expq[i][j].d));
                chk({tag, "_last"}, 32'(rxq[i][j].last), 32'(expq[i][j].last));
            end
        end
        clr();
    endtask

    initial begin : main
        vec_t vec [5];
        int   exp_order [6];
        vec[0] = '{0, 3, {8'd100, 8'd100, 8'd100}, 8'd100};
        vec[1] = '{1, 3, {8'd200, 8'd200, 8'd200}, 8'd200};
        vec[2] = '{0, 1, {8'd30, 8'd60, 8'd90}, 8'd60};
        vec[3] = '{1, 4, {8'd255, 8'd0, 8'd0}, 8'd85};
        vec[4] = '{0, 2, {8'd0, 8'd0, 8'd3}, 8'd1};
        exp_order = '{0, 0, 1, 1, 0, 0};
        rst = 1; s_tdata = '0; s_tvalid = '0; s_tlast = '0; c_tready = 0;
        c_rdata = '0; c_rvalid = 0; m_tready = '0;
        for (int i = 0; i < N; i++) hold[i] = 0;
        do_reset();

        for (int t = 0; t < 5; t++) begin
            send_pkt(vec[t].src, vec[t].beats, vec[t].rgb, 0);
            wait_idle(200);
            chk("tbl_count", 32'(rxq[vec[t].src].size()), 32'(vec[t].beats));
            foreach (rxq[vec[t].src][j]) begin
                chk("tbl_data", 32'(rxq[vec[t].src][j].d), 32'(vec[t].exp));
                chk("tbl_last", 32'(rxq[vec[t].src][j].last), 32'(j == vec[t].beats - 1));
            end
            for (int i = 0; i < N; i++)
                if (i != vec[t].src) chk("tbl_other_silent", 32'(rxq[i].size()), 32'(0));
            chk("tbl_grant_id", 32'(grant_id), 32'(vec[t].src));
            clr();
        end

        do_reset();
        clr();
        send_pkt(0, 2, '0, 1);
        send_pkt(0, 2, '0, 1);
        send_pkt(1, 2, '0, 1);
        wait_idle(200);
        chk("rr_issue_count", 32'(issue_log.size()), 32'(6));
        for (int j = 0; j < 6 && j < issue_log.size(); j++) chk("rr_order", 32'(issue_log[j]), 32'(exp_order[j]));
        chk("rr_grant_id", 32'(grant_id), 32'(0));
        compare_all("rr");

        do_reset();
        clr();
        hold[0] = 1;
        send_pkt(0, 12, '0, 1);
        repeat (14) @(negedge clk);
        chk("bp_issues_at_full", 32'(issue_log.size()), 32'(8));
        chk("bp_s_tready", 32'(s_tready[0]), 32'(0));
        chk("bp_c_tvalid", 32'(c_tvalid), 32'(0));
        chk("bp_s_tvalid", 32'(s_tvalid[0]), 32'(1));
        chk("bp_busy", 32'(busy), 32'(1));
        hold[0] = 0;
        wait_idle(300);
        compare_all("bp");

        send_pkt(0, 3, {8'd50, 8'd50, 8'd50}, 0);
        send_pkt(1, 3, {8'd200, 8'd200, 8'd200}, 0);
        wait_idle(200);
        chk("il_count0", 32'(rxq[0].size()), 32'(3));
        chk("il_count1", 32'(rxq[1].size()), 32'(3));
        foreach (rxq[0][j]) chk("il_port0_data", 32'(rxq[0][j].d), 32'(50));
        foreach (rxq[1][j]) chk("il_port1_data", 32'(rxq[1][j].d), 32'(200));
        clr();

        chk("orphan_clear_before", 32'(err_orphan), 32'(0));
        inject = 1;
        @(negedge clk);
        @(negedge clk);
        chk("orphan_drain_ready", 32'(c_rready), 32'(1));
        @(negedge clk);
        chk("orphan_set", 32'(err_orphan), 32'(1));
        repeat (5) @(negedge clk);
        chk("orphan_sticky", 32'(err_orphan), 32'(1));
        @(posedge clk);
        #2;
        do_reset();

        clr();
        send_pkt(1, 4, '0, 1);
        for (int c = 0; c < 50 && issue_log.size() < 2; c++) begin
            @(posedge clk);
            #2;
        end
        chk("mid_beats_before_rst", 32'(issue_log.size()), 32'(2));
        do_reset();
        chk("mid_no_issue_in_rst", 32'(issue_log.size()), 32'(2));
        clr();
        send_pkt(1, 2, '0, 1);
        send_pkt(0, 2, '0, 1);
        wait_idle(200);
        chk("mid_next_grant", 32'(issue_log.size() > 0 ? issue_log[0] : -1), 32'(0));
        compare_all("mid");

        do_reset();
        clr();
        rnd = 1;
        for (int k = 0; k < 60; k++) send_pkt(int'($urandom % N), int'($urandom_range(1, 5)), '0, 1);
        wait_idle(8000);
        rnd = 0;
        compare_all("rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
